// File: rtl/player_motion_ctrl.sv
// Player motion controller: synchronises and debounces left/right buttons, drives a
// HOLD/LEFT/RIGHT FSM and steps the clamped player column. Optional: PLAYER_ACCEL_EN.
//
// state    | meaning
// ST_HOLD  | no single button held (none or both); position frozen, tick idle
// ST_LEFT  | left only; step left on entry+1, then every MOVE_TICKS cycles
// ST_RIGHT | right only; step right on entry+1, then every MOVE_TICKS cycles
module player_motion_ctrl #(
    parameter int DEB_CYCLES  = 31500,
    parameter int MOVE_TICKS  = 262144,
    parameter int STEP        = 4,
    parameter int COL_MIN     = 8,
    parameter int COL_MAX     = 616,
    parameter int COL_INIT    = 312,
    parameter int ACCEL_STEPS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [11:0] btn_col,
    output logic [1:0]  player_dir,
    output logic        at_edge
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int TICK_W = $clog2(MOVE_TICKS + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MOVE_TICKS - 1);
    localparam logic [11:0]       MIN12     = 12'(COL_MIN);
    localparam logic [11:0]       MAX12     = 12'(COL_MAX);
    localparam logic [12:0]       MIN13     = 13'(COL_MIN);
    localparam logic [12:0]       MAX13     = 13'(COL_MAX);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'b00,
        ST_LEFT  = 2'b01,
        ST_RIGHT = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_l, sync_r;
    logic [1:0]         s_vec;      // [0] left, [1] right
    logic [1:0]         deb_vec;
    logic [DEB_W-1:0]   deb_cnt [2];
    logic [TICK_W-1:0]  tick_cnt;
    logic               step_en;
    logic [11:0]        step_amt;
    logic [12:0]        sum13;
    logic [11:0]        col_d;
    logic               edge_d;

    // Two-flop synchronisers for the asynchronous buttons
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_l <= '0;
            sync_r <= '0;
        end else begin
            sync_l <= {sync_l[0], btn_left};
            sync_r <= {sync_r[0], btn_right};
        end
    end

    assign s_vec = {sync_r[1], sync_l[1]};

    // A level is accepted only after DEB_CYCLES consecutive cycles of disagreement
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_vec <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s_vec[i] == deb_vec[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_vec[i] <= s_vec[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_HOLD;
        else     state_q <= state_d;
    end

`ifdef PLAYER_ACCEL_EN
    localparam logic [4:0] ACCEL_SAT = 5'(ACCEL_STEPS);
    logic [4:0] run_cnt;

    // Run length of same-direction steps; a direction change or HOLD restarts it
    always_ff @(posedge clk) begin
        if (rst)
            run_cnt <= '0;
        else if (state_d != state_q || state_q == ST_HOLD)
            run_cnt <= '0;
        else if (step_en && run_cnt < ACCEL_SAT)
            run_cnt <= run_cnt + 1'b1;
    end

    assign step_amt = (run_cnt >= ACCEL_SAT) ? 12'(2 * STEP) : 12'(STEP);
`else
    assign step_amt = 12'(STEP);
`endif

    always_comb begin
        state_d = ST_HOLD;
        step_en = 1'b0;
        sum13   = '0;
        col_d   = btn_col;
        edge_d  = at_edge;

        if (deb_vec[0] && !deb_vec[1])      state_d = ST_LEFT;
        else if (deb_vec[1] && !deb_vec[0]) state_d = ST_RIGHT;

        step_en = (state_q != ST_HOLD) && (tick_cnt == '0);

        // 13-bit compares so neither direction can wrap before clamping
        if (state_q == ST_LEFT) begin
            sum13 = {1'b0, btn_col};
            if (sum13 < MIN13 + {1'b0, step_amt}) col_d = MIN12;
            else                                  col_d = btn_col - step_amt;
        end else if (state_q == ST_RIGHT) begin
            sum13 = {1'b0, btn_col} + {1'b0, step_amt};
            if (sum13 > MAX13) col_d = MAX12;
            else               col_d = sum13[11:0];
        end

        edge_d = (col_d == MIN12) || (col_d == MAX12);
    end

    // Rate timer: loaded to zero on entry so the first step lands one edge later
    always_ff @(posedge clk) begin
        if (rst)
            tick_cnt <= '0;
        else if (state_d != state_q || state_q == ST_HOLD)
            tick_cnt <= '0;
        else if (tick_cnt == '0)
            tick_cnt <= TICK_LAST;
        else
            tick_cnt <= tick_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_col <= 12'(COL_INIT);
            at_edge <= 1'b0;
        end else if (step_en) begin
            btn_col <= col_d;
            at_edge <= edge_d;
        end
    end

    assign player_dir = state_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed scenarios plus random button activity, all
// compared each cycle against a cycle-level behavioural model of the button rules.
module tb_player_motion_ctrl;

    localparam int DEB   = 4;
    localparam int TICKS = 8;
    localparam int STP   = 4;
    localparam int CMIN  = 8;
    localparam int CMAX  = 616;
    localparam int CINIT = 312;
    localparam int ACC   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic [11:0] btn_col;
    logic [1:0]  player_dir;
    logic        at_edge;

    int checks = 0;
    int errors = 0;

    // model state
    int m_s1[2], m_s2[2], m_deb[2], m_dis[2];
    int m_dir, m_age, m_pos, m_run, m_edge;

    player_motion_ctrl #(
        .DEB_CYCLES(DEB), .MOVE_TICKS(TICKS), .STEP(STP), .COL_MIN(CMIN),
        .COL_MAX(CMAX), .COL_INIT(CINIT), .ACCEL_STEPS(ACC)
    ) dut (
        .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
        .btn_col(btn_col), .player_dir(player_dir), .at_edge(at_edge)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int accel_on();
`ifdef PLAYER_ACCEL_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    // Advance the model by one clock edge using the inputs held before the edge.
    task automatic model_edge();
        int raw[2];
        int new_dir, amt;
        bit step;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_dis[i] = 0;
            end
            m_dir = 0; m_age = 0; m_pos = CINIT; m_run = 0; m_edge = 0;
            return;
        end
        raw[0] = int'(btn_left);
        raw[1] = int'(btn_right);
        if (m_deb[0] == 1 && m_deb[1] == 0)      new_dir = 1;
        else if (m_deb[1] == 1 && m_deb[0] == 0) new_dir = 2;
        else                                     new_dir = 0;
        for (int i = 0; i < 2; i++) begin
            if (m_s2[i] != m_deb[i]) begin
                m_dis[i]++;
                if (m_dis[i] == DEB) begin
                    m_deb[i] = m_s2[i];
                    m_dis[i] = 0;
                end
            end else begin
                m_dis[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
        step = (m_dir != 0) && ((m_age % TICKS) == 0);
        amt = (accel_on() != 0 && m_run >= ACC) ? 2 * STP : STP;
        if (step) begin
            if (m_dir == 1) m_pos = (m_pos - amt < CMIN) ? CMIN : m_pos - amt;
            else            m_pos = (m_pos + amt > CMAX) ? CMAX : m_pos + amt;
            m_edge = (m_pos == CMIN || m_pos == CMAX) ? 1 : 0;
        end
        if (new_dir != m_dir || m_dir == 0) m_run = 0;
        else if (step && m_run < ACC)       m_run++;
        if (new_dir != m_dir || new_dir == 0) m_age = 0;
        else                                  m_age++;
        m_dir = new_dir;
    endtask

    task automatic do_cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_val("btn_col", int'(btn_col), m_pos);
        check_val("player_dir", int'(player_dir), m_dir);
        check_val("at_edge", int'(at_edge), m_edge);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    initial begin
        int pat, len;
        rst = 1'b1;
        run_cycles(3);
        rst = 1'b0;
        check_val("reset_col", int'(btn_col), 312);
        check_val("reset_dir", int'(player_dir), 0);
        check_val("reset_edge", int'(at_edge), 0);

        // short glitch must be filtered
        btn_right = 1'b1;
        run_cycles(3);
        btn_right = 1'b0;
        run_cycles(12);
        check_val("glitch_col", int'(btn_col), 312);
        check_val("glitch_dir", int'(player_dir), 0);

        // hold right: step cadence from the first raw edge
        btn_right = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            do_cycle();
            if (j == 7)  check_val("right_k7", int'(btn_col), 312);
            if (j == 8)  check_val("right_k8", int'(btn_col), 316);
            if (j == 16) check_val("right_k16", int'(btn_col), 320);
            if (j == 24) check_val("right_k24", int'(btn_col), 324);
            if (j == 32) check_val("right_k32", int'(btn_col), accel_on() != 0 ? 332 : 328);
        end

        // both held freezes, releasing left resumes right
        btn_left = 1'b1;
        run_cycles(30);
        check_val("both_dir", int'(player_dir), 0);
        btn_left = 1'b0;
        run_cycles(30);
        check_val("resume_dir", int'(player_dir), 2);

        // reset mid-move
        rst = 1'b1;
        do_cycle();
        check_val("midrst_col", int'(btn_col), 312);
        check_val("midrst_dir", int'(player_dir), 0);
        check_val("midrst_edge", int'(at_edge), 0);
        do_cycle();
        rst = 1'b0;

        // run into the left clamp, then step back right
        btn_right = 1'b0;
        btn_left  = 1'b1;
        run_cycles(1300);
        check_val("lclamp_col", int'(btn_col), 8);
        check_val("lclamp_edge", int'(at_edge), 1);
        btn_left  = 1'b0;
        btn_right = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            do_cycle();
            if (j == 7) check_val("unclamp_k7", int'(btn_col), 8);
            if (j == 8) begin
                check_val("unclamp_col", int'(btn_col), 12);
                check_val("unclamp_edge", int'(at_edge), 0);
            end
        end
        btn_right = 1'b0;

        // random activity including sub-debounce glitches and occasional resets
        for (int seg = 0; seg < 80; seg++) begin
            pat = $urandom_range(0, 3);
            len = (($urandom_range(0, 3)) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 60);
            btn_left  = pat[0];
            btn_right = pat[1];
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                run_cycles($urandom_range(1, 2));
                rst = 1'b0;
            end
            run_cycles(len);
        end
        btn_left  = 1'b0;
        btn_right = 1'b0;
        run_cycles(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
